// File: rtl/mod_beep_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mod_beep_seq
//  Description : Beep-pattern sequencer driving the trigger/busy handshake of
//                mod_buzzer. Issues a programmed number of triggers, waits for
//                each buzzer cycle to end and inserts a millisecond gap between
//                beeps. Aborts with an error pulse on acknowledge timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_beep_seq #(
   parameter int CLK_PER_MS = 1000,
   parameter int ACK_TO     = 4096
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [7:0]  count_i,
   input  logic [15:0] gap_ms_i,
   input  logic        abort_i,
   input  logic        buz_cyc_i,
   output logic        trig_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o
);

   // Counter widths; a floor of one bit keeps degenerate parameters legal.
   localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
   localparam int TW = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_MS - 1);
   localparam logic [TW-1:0] TMO_LAST   = TW'(ACK_TO - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      TRIG     = 3'd1,
      WAIT_END = 3'd2,
      GAP      = 3'd3,
      FIN      = 3'd4
   } state_t;

   state_t          state;
   logic [7:0]      rem;       // beeps still to be issued, including current
   logic [15:0]     gap;       // latched inter-beep gap in ms
   logic [15:0]     gap_cnt;   // ms remaining in the current gap
   logic [PW-1:0]   presc;     // cycle position within the current ms
   logic [TW-1:0]   tmo;       // cycles spent waiting for the buzzer ack

   // Sequencer state machine; every output is set on the transition into the
   // state that owns it so all outputs come straight from flops.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state   <= IDLE;
         rem     <= 8'd0;
         gap     <= 16'd0;
         gap_cnt <= 16'd0;
         presc   <= '0;
         tmo     <= '0;
         trig_o  <= 1'b0;
         busy_o  <= 1'b0;
         done_o  <= 1'b0;
         err_o   <= 1'b0;
      end else begin
         done_o <= 1'b0;
         err_o  <= 1'b0;
         if (abort_i) begin
            // A buzzer cycle already running is left to finish on its own.
            state  <= IDLE;
            trig_o <= 1'b0;
            busy_o <= 1'b0;
            presc  <= '0;
            tmo    <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (start_i) begin
                     rem    <= count_i;
                     gap    <= gap_ms_i;
                     busy_o <= 1'b1;
                     if (count_i == 8'd0) begin
                        state  <= FIN;
                        done_o <= 1'b1;
                     end else begin
                        state  <= TRIG;
                        trig_o <= 1'b1;
                        tmo    <= '0;
                     end
                  end
               end

               TRIG: begin
                  // Ack takes priority over a timeout expiring on the same edge.
                  if (buz_cyc_i) begin
                     state  <= WAIT_END;
                     trig_o <= 1'b0;
                     tmo    <= '0;
                  end else if (tmo == TMO_LAST) begin
                     state  <= IDLE;
                     trig_o <= 1'b0;
                     busy_o <= 1'b0;
                     err_o  <= 1'b1;
                     tmo    <= '0;
                  end else begin
                     tmo <= tmo + 1'b1;
                  end
               end

               WAIT_END: begin
                  if (!buz_cyc_i) begin
                     rem <= rem - 8'd1;
                     if (rem == 8'd1) begin
                        state  <= FIN;
                        done_o <= 1'b1;
                     end else if (gap == 16'd0) begin
                        state  <= TRIG;
                        trig_o <= 1'b1;
                        tmo    <= '0;
                     end else begin
                        state   <= GAP;
                        gap_cnt <= gap;
                        presc   <= '0;
                     end
                  end
               end

               GAP: begin
                  // Gap lasts gap * CLK_PER_MS cycles: leave on the last wrap.
                  if (presc == PRESC_LAST) begin
                     presc   <= '0;
                     gap_cnt <= gap_cnt - 16'd1;
                     if (gap_cnt == 16'd1) begin
                        state  <= TRIG;
                        trig_o <= 1'b1;
                        tmo    <= '0;
                     end
                  end else begin
                     presc <= presc + 1'b1;
                  end
               end

               FIN: begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end

               default: begin
                  state  <= IDLE;
                  trig_o <= 1'b0;
                  busy_o <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mod_beep_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mod_beep_seq
//  Description : Self-checking bench for mod_beep_seq. A reactive buzzer model
//                answers triggers; expected per-cycle outputs are derived from
//                an arithmetic timeline of each beep pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_beep_seq;

   localparam int CPM   = 10;
   localparam int ACKTO = 16;
   localparam int MAXR  = 600;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        start_i = 1'b0;
   logic [7:0]  count_i = 8'd0;
   logic [15:0] gap_ms_i = 16'd0;
   logic        abort_i = 1'b0;
   logic        buz_cyc_i = 1'b0;
   logic        trig_o, busy_o, done_o, err_o;

   int nvec = 0;
   int nerr = 0;

   mod_beep_seq #(.CLK_PER_MS(CPM), .ACK_TO(ACKTO)) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .start_i   (start_i),
      .count_i   (count_i),
      .gap_ms_i  (gap_ms_i),
      .abort_i   (abort_i),
      .buz_cyc_i (buz_cyc_i),
      .trig_o    (trig_o),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .err_o     (err_o)
   );

   always #5 clk_i = ~clk_i;

   // Buzzer model: after seeing a trigger rise it is busy for bz_l cycles
   // starting bz_d cycles later; the rise numbered bz_noack_abs is ignored.
   int bz_d = 2, bz_l = 4, bz_k = 0, bz_rises = 0, bz_noack_abs = -1;
   bit bz_prev = 1'b0, bz_active = 1'b0;

   always @(negedge clk_i) begin
      if (trig_o && !bz_prev) begin
         bz_active <= (bz_rises != bz_noack_abs);
         bz_rises  <= bz_rises + 1;
         bz_k      <= 1;
         buz_cyc_i <= 1'b0;
      end else begin
         bz_k      <= bz_k + 1;
         buz_cyc_i <= bz_active && (bz_k >= bz_d) && (bz_k < bz_d + bz_l);
      end
      bz_prev <= trig_o;
   end

   // Expected outputs per cycle, cycle 0 being the one after start acceptance.
   bit e_trig [MAXR];
   bit e_busy [MAXR];
   bit e_done [MAXR];
   bit e_err  [MAXR];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp, input int r);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s cycle=%0d got=%0d want=%0d", nm, r, act, exp);
      end
   endtask

   // Timeline: trigger high from its rise T through T+d, buzzer ack sampled
   // then, fall seen at T+d+l+1 where the next phase starts.
   task automatic build(input int cnt, input int g, input int d, input int l,
                        input int noack, input int kill_r, output int end_r);
      int t, k;
      for (int i = 0; i < MAXR; i++) begin
         e_trig[i] = 1'b0; e_busy[i] = 1'b0; e_done[i] = 1'b0; e_err[i] = 1'b0;
      end
      t = 0;
      end_r = 1;
      if (cnt == 0) begin
         e_busy[0] = 1'b1;
         e_done[0] = 1'b1;
      end else begin
         for (int b = 0; b < cnt; b++) begin
            if (b == noack) begin
               for (int i = 0; i < ACKTO; i++) begin
                  e_trig[t+i] = 1'b1;
                  e_busy[t+i] = 1'b1;
               end
               e_err[t+ACKTO] = 1'b1;
               end_r = t + ACKTO + 1;
               break;
            end
            for (int i = 0; i <= d; i++) e_trig[t+i] = 1'b1;
            k = t + d + l + 1;
            for (int i = t; i < k; i++) e_busy[i] = 1'b1;
            if (b == cnt - 1) begin
               e_busy[k] = 1'b1;
               e_done[k] = 1'b1;
               end_r = k + 1;
            end else begin
               for (int i = k; i < k + g*CPM; i++) e_busy[i] = 1'b1;
               t = k + g*CPM;
            end
         end
      end
      if (kill_r >= 0 && kill_r < end_r) begin
         for (int i = kill_r + 1; i < MAXR; i++) begin
            e_trig[i] = 1'b0; e_busy[i] = 1'b0; e_done[i] = 1'b0; e_err[i] = 1'b0;
         end
         end_r = kill_r + 1;
      end
   endtask

   // Runs one pattern from the current negedge; kill_r is the cycle in which
   // abort (or reset when kill_rst) is driven.
   task automatic run(input int cnt, input int g, input int d, input int l,
                      input int noack, input int kill_r, input bit kill_rst, input int tail,
                      output int rises, output int trigc, output int busyc,
                      output int donec, output int errc);
      int end_r;
      bit prev;
      build(cnt, g, d, l, noack, kill_r, end_r);
      bz_d = d;
      bz_l = l;
      bz_noack_abs = (noack >= 0) ? bz_rises + noack : -1;
      start_i  = 1'b1;
      count_i  = cnt[7:0];
      gap_ms_i = g[15:0];
      @(negedge clk_i);
      rises = 0; trigc = 0; busyc = 0; donec = 0; errc = 0;
      prev = 1'b0;
      for (int r = 0; r < end_r + tail; r++) begin
         chk("trig", {31'd0, trig_o}, {31'd0, e_trig[r]}, r);
         chk("busy", {31'd0, busy_o}, {31'd0, e_busy[r]}, r);
         chk("done", {31'd0, done_o}, {31'd0, e_done[r]}, r);
         chk("err",  {31'd0, err_o},  {31'd0, e_err[r]},  r);
         if (trig_o === 1'b1 && !prev) rises++;
         prev = (trig_o === 1'b1);
         if (trig_o === 1'b1) trigc++;
         if (busy_o === 1'b1) busyc++;
         if (done_o === 1'b1) donec++;
         if (err_o === 1'b1) errc++;
         // Start and operand noise while busy must be ignored.
         start_i  = e_busy[r] ? 1'($urandom % 2) : 1'b0;
         count_i  = 8'($urandom);
         gap_ms_i = 16'($urandom % 4);
         abort_i  = (!kill_rst && r == kill_r);
         rst_i    = !(kill_rst && r == kill_r);
         @(negedge clk_i);
      end
      start_i = 1'b0;
      abort_i = 1'b0;
      rst_i   = 1'b1;
   endtask

   typedef struct {
      int cnt, gap, d, l, noack, kill_r;
      bit kill_rst;
      int x_rises, x_trig, x_busy, x_done, x_err;
   } vec_t;

   vec_t tbl [8];

   initial begin
      int rs, tc, bc, dc, ec;
      int cnt, g, d, l, na, kr, tail;
      bit krst;

      tbl[0] = '{1, 5, 2, 20, -1, -1, 1'b0, 1, 3, 24, 1, 0};  // single beep
      tbl[1] = '{3, 2, 2, 4,  -1, -1, 1'b0, 3, 9, 62, 1, 0};  // 3 beeps, 2 ms gap
      tbl[2] = '{0, 7, 1, 1,  -1, -1, 1'b0, 0, 0, 1,  1, 0};  // zero beeps
      tbl[3] = '{2, 0, 1, 3,  -1, -1, 1'b0, 2, 4, 11, 1, 0};  // zero gap
      tbl[4] = '{1, 0, 1, 1,   0, -1, 1'b0, 1, 16, 16, 0, 1}; // timeout
      tbl[5] = '{3, 1, 3, 2,   1, -1, 1'b0, 2, 20, 32, 0, 1}; // timeout on 2nd
      tbl[6] = '{3, 2, 2, 4,  -1, 12, 1'b0, 1, 3, 13, 0, 0};  // abort in GAP
      tbl[7] = '{2, 0, 4, 3,  -1,  1, 1'b1, 1, 2, 2,  0, 0};  // reset mid-TRIG

      // Reset held with start asserted: nothing may happen.
      rst_i   = 1'b0;
      start_i = 1'b1;
      count_i = 8'd2;
      @(posedge clk_i);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         chk("rst_trig", {31'd0, trig_o}, 32'd0, i);
         chk("rst_busy", {31'd0, busy_o}, 32'd0, i);
         chk("rst_done", {31'd0, done_o}, 32'd0, i);
         chk("rst_err",  {31'd0, err_o},  32'd0, i);
      end
      rst_i   = 1'b1;
      start_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk_i);
         chk("idle_busy", {31'd0, busy_o}, 32'd0, i);
         chk("idle_trig", {31'd0, trig_o}, 32'd0, i);
      end

      for (int v = 0; v < 8; v++) begin
         run(tbl[v].cnt, tbl[v].gap, tbl[v].d, tbl[v].l, tbl[v].noack,
             tbl[v].kill_r, tbl[v].kill_rst, (tbl[v].kill_r >= 0) ? 40 : 3,
             rs, tc, bc, dc, ec);
         chk("tbl_rises", rs, tbl[v].x_rises, v);
         chk("tbl_trigc", tc, tbl[v].x_trig,  v);
         chk("tbl_busyc", bc, tbl[v].x_busy,  v);
         chk("tbl_donec", dc, tbl[v].x_done,  v);
         chk("tbl_errc",  ec, tbl[v].x_err,   v);
      end

      // Randomized patterns, some back-to-back, some aborted or reset.
      for (int s = 0; s < 40; s++) begin
         cnt = ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, 4));
         g   = int'($urandom_range(0, 3));
         d   = int'($urandom_range(1, 5));
         l   = int'($urandom_range(1, 6));
         na  = (cnt > 0 && $urandom % 5 == 0) ? int'($urandom_range(0, cnt - 1)) : -1;
         kr  = ($urandom % 7 == 0) ? int'($urandom_range(0, 60)) : -1;
         krst = 1'($urandom % 2);
         tail = (kr >= 0) ? 40 : (($urandom % 2 == 0) ? 0 : int'($urandom_range(1, 4)));
         run(cnt, g, d, l, na, kr, krst, tail, rs, tc, bc, dc, ec);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mod_beep_seq.md
# mod_beep_seq

Beep-pattern sequencer that drives the trigger/busy handshake of `mod_buzzer` from the initiator side. On a start request it issues a programmed number of buzzer triggers, waits for each buzzer cycle to complete and inserts a programmed millisecond gap between beeps. It sits between control logic (button handling, status reporting) and `mod_buzzer`, in the buzzer's 1 MHz clock domain, replacing ad-hoc single-shot trigger logic.

## Interface
- `CLK_PER_MS`, 1000: clock cycles per millisecond (1000 for the 1 MHz buzzer clock).
- `ACK_TO`, 4096: maximum cycles `trig_o` waits for `buz_cyc_i` to rise before aborting with error.
- `clk_i`  in  1  sequencer clock, same clock as the driven `mod_buzzer`.
- `rst_i`  in  1  reset; one clock; reset is synchronous and active-low.
- `start_i`  in  1  start request, sampled each cycle; honoured only in IDLE.
- `count_i`  in  8  number of beeps; latched on accepted start.
- `gap_ms_i`  in  16  gap between beeps in ms; latched on accepted start.
- `abort_i`  in  1  synchronous abort; returns to IDLE from any state.
- `buz_cyc_i`  in  1  buzzer busy (`cyc_o` of `mod_buzzer`).
- `trig_o`  out  1  buzzer trigger (`trig_i` of `mod_buzzer`).
- `busy_o`  out  1  high whenever state is not IDLE.
- `done_o`  out  1  one-cycle pulse: pattern completed normally.
- `err_o`  out  1  one-cycle pulse: acknowledge timeout.

## Operation
- States: IDLE, TRIG, WAIT_END, GAP, FIN.
- Reset (`rst_i`=0 at a rising edge): state IDLE; `trig_o`, `busy_o`, `done_o`, `err_o` = 0; remaining-beep counter, gap counter, ms prescaler and timeout counter = 0. Reset wins over all other inputs.
- IDLE: on `start_i`=1, latch `count_i`→`rem`, `gap_ms_i`→`gap`. If `count_i`=0 → FIN (no trigger issued); else → TRIG.
- TRIG: `trig_o`=1; timeout counter increments each cycle. On `buz_cyc_i`=1 sampled → WAIT_END, `trig_o` falls the next cycle. If timeout counter reaches `ACK_TO`-1 without ack → IDLE, `err_o` pulses, no `done_o`.
- WAIT_END: `trig_o`=0. On `buz_cyc_i`=0 sampled: `rem` decrements; if new `rem`=0 → FIN; else if `gap`=0 → TRIG; else → GAP.
- GAP: prescaler counts 0..`CLK_PER_MS`-1; each wrap decrements gap counter (loaded from `gap` on entry). When the last ms wraps → TRIG. The gap lasts exactly `gap`×`CLK_PER_MS` cycles.
- FIN: `done_o`=1 for exactly one cycle, then IDLE.
- `abort_i`=1 (priority below reset, above all else): next state IDLE, `trig_o`=0, no `done_o`/`err_o`. A buzzer cycle already running is not cancelled.
- `start_i` outside IDLE is ignored, not queued. `count_i`/`gap_ms_i` changes after acceptance have no effect.
- Counters: `rem` 8 bit, gap counter 16 bit, prescaler `$clog2(CLK_PER_MS)` bit, timeout `$clog2(ACK_TO)` bit; no wrap-around possible within legal operation.

## Timing
- All outputs registered; no combinational input→output paths.
- Start accepted at edge N → `busy_o`=1, `trig_o`=1 from N+1.
- `buz_cyc_i` sampled high at edge M → `trig_o`=0 from M+1.
- Last `buz_cyc_i` fall sampled at edge K → `done_o`=1 for cycle K+1 (FIN), `busy_o`=0 from K+2.
- `count_i`=0: start at N → `done_o` during N+1, IDLE at N+2.
- Inter-beep: fall sampled at K → `trig_o` rises at K+1 (gap 0) or at K+1+`gap`×`CLK_PER_MS` (GAP).
- Back-to-back: a new start is accepted in the first IDLE cycle after `done_o`.

## Test plan
- Reset: hold `rst_i`=0 for 3 cycles with `start_i`=1 → all outputs 0, no trigger; release → IDLE.
- Single beep: `count_i`=1, `gap_ms_i`=5, buzzer model busy 20 cycles after 2-cycle ack delay → one `trig_o` pulse of 3 cycles, `done_o` once, no gap inserted.
- Pattern: `count_i`=3, `gap_ms_i`=2, `CLK_PER_MS`=10 → three triggers; rising `trig_o` edges 20 cycles after each sampled buzzer fall; `done_o` exactly once after third fall.
- Zero cases: `count_i`=0 → `done_o` at N+1, `trig_o` never asserted; `count_i`=2, `gap_ms_i`=0 → second trigger 1 cycle after first fall.
- Timeout: `ACK_TO`=16, `buz_cyc_i` held 0 → `trig_o` high 16 cycles, `err_o` one pulse, IDLE, no `done_o`.
- Abort/restart: `abort_i` pulse in GAP of a 3-beep pattern → IDLE next cycle, no further triggers, no `done_o`; `start_i` during busy ignored; `rst_i`=0 mid-TRIG → `trig_o`=0 next cycle.
